wb_counter_csr: RTL and testbench



---
 rtl/wb_counter_pkg.sv | 33 +++
 rtl/wb_counter_csr.sv | 133 +++++++++++++
 tb/tb_wb_counter_csr.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_counter_pkg.sv
// ---------------------------------------------------------------------------
// wb_counter_pkg
//
// Shared definitions for the Wishbone counter CSR block.
//   - CSR_* : byte offsets of each register inside the 256-byte window
//   - CTRL_*: bit positions inside the CTRL register
//   - sel_merge(): byte-lane merge used by every writable register
// ---------------------------------------------------------------------------
package wb_counter_pkg;

    localparam logic [7:0] CSR_CTRL   = 8'h00;
    localparam logic [7:0] CSR_LOAD   = 8'h04;
    localparam logic [7:0] CSR_COUNT  = 8'h08;
    localparam logic [7:0] CSR_CMP    = 8'h0C;
    localparam logic [7:0] CSR_STATUS = 8'h10;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IRQEN = 1;
    localparam int CTRL_DIR   = 2;

    // Replace only the bytes whose lane enable is set; the rest keep the
    // old register contents.
    function automatic logic [31:0] sel_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
        logic [31:0] merged;
        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_counter_csr.sv
// ---------------------------------------------------------------------------
// wb_counter_csr
//
// Wishbone classic slave that exposes the counter_tlv core as a small CSR
// block: control, load value, live count, compare value and a sticky match
// status that drives a maskable interrupt.
//
// Ports
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   wbs_*                     : Wishbone slave port (classic, single-cycle ack)
//   cnt_en_o, cnt_dir_o       : count enable / direction (1 = down) to the core
//   cnt_load_o, cnt_load_val_o: one-cycle load strobe and the value to load
//   cnt_cmp_o                 : compare value to the core
//   cnt_val_i, cnt_match_i    : live count and match pulse from the core
//   irq_o                     : sticky match status gated by irq_en
// ---------------------------------------------------------------------------
import wb_counter_pkg::*;

module wb_counter_csr #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             cnt_en_o,
    output logic             cnt_dir_o,
    output logic             cnt_load_o,
    output logic [CNT_W-1:0] cnt_load_val_o,
    output logic [CNT_W-1:0] cnt_cmp_o,
    input  logic [CNT_W-1:0] cnt_val_i,
    input  logic             cnt_match_i,
    output logic             irq_o
);

    logic [2:0]       ctrl_q;
    logic [CNT_W-1:0] load_q;
    logic [CNT_W-1:0] cmp_q;
    logic             status_q;

    logic             hit;
    logic             access;
    logic             wr_access;
    logic             rd_access;
    logic [7:0]       offset;
    logic [31:0]      ctrl_ext;
    logic [31:0]      load_ext;
    logic [31:0]      cmp_ext;
    logic [31:0]      cnt_ext;
    logic [31:0]      ctrl_merged;
    logic [31:0]      load_merged;
    logic [31:0]      cmp_merged;
    logic [31:0]      rd_data;
    logic             status_clr;
    logic             unused_bits;

    // Window decode. The ~ack term makes every access exactly one ack long
    // and forces an idle cycle between back-to-back accesses on a held stb.
    assign hit       = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign access    = wbs_cyc_i & wbs_stb_i & hit & ~wbs_ack_o;
    assign wr_access = access & wbs_we_i;
    assign rd_access = access & ~wbs_we_i;
    assign offset    = {wbs_adr_i[7:2], 2'b00};

    assign ctrl_ext    = {29'd0, ctrl_q};
    assign load_ext    = 32'(load_q);
    assign cmp_ext     = 32'(cmp_q);
    assign cnt_ext     = 32'(cnt_val_i);
    assign ctrl_merged = sel_merge(ctrl_ext, wbs_dat_i, wbs_sel_i);
    assign load_merged = sel_merge(load_ext, wbs_dat_i, wbs_sel_i);
    assign cmp_merged  = sel_merge(cmp_ext,  wbs_dat_i, wbs_sel_i);

    // W1C only through byte lane 0, which is where the match bit lives.
    assign status_clr = wr_access & (offset == CSR_STATUS)
                      & wbs_sel_i[0] & wbs_dat_i[0];

    assign unused_bits = ^{wbs_adr_i[1:0], ctrl_merged[31:3]};

    // Read mux; undefined offsets in the window return zero.
    always_comb begin
        rd_data = 32'd0;
        case (offset)
            CSR_CTRL:   rd_data = ctrl_ext;
            CSR_LOAD:   rd_data = load_ext;
            CSR_COUNT:  rd_data = cnt_ext;
            CSR_CMP:    rd_data = cmp_ext;
            CSR_STATUS: rd_data = {31'd0, status_q};
            default:    rd_data = 32'd0;
        endcase
    end

    // Handshake, read capture, register writes and the load strobe all
    // happen on the edge that raises ack. A match pulse sets STATUS even
    // when a W1C lands in the same cycle, so no event is ever lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= 32'd0;
            cnt_load_o <= 1'b0;
            ctrl_q     <= 3'd0;
            load_q     <= '0;
            cmp_q      <= '0;
            status_q   <= 1'b0;
        end else begin
            wbs_ack_o  <= access;
            wbs_dat_o  <= rd_access ? rd_data : 32'd0;
            cnt_load_o <= wr_access & (offset == CSR_LOAD) & (|wbs_sel_i);
            if (wr_access) begin
                case (offset)
                    CSR_CTRL: ctrl_q <= ctrl_merged[2:0];
                    CSR_LOAD: load_q <= load_merged[CNT_W-1:0];
                    CSR_CMP:  cmp_q  <= cmp_merged[CNT_W-1:0];
                    default:  ;
                endcase
            end
            status_q <= cnt_match_i | (status_q & ~status_clr);
        end
    end

    assign cnt_en_o       = ctrl_q[CTRL_EN];
    assign cnt_dir_o      = ctrl_q[CTRL_DIR];
    assign cnt_load_val_o = load_q;
    assign cnt_cmp_o      = cmp_q;
    assign irq_o          = status_q & ctrl_q[CTRL_IRQEN];

endmodule

// File: tb/tb_wb_counter_csr.sv
// ---------------------------------------------------------------------------
// tb_wb_counter_csr
//
// Directed bench for wb_counter_csr. Bus accesses go through applyStimulus,
// every comparison goes through checkOutput. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point.
// ---------------------------------------------------------------------------
module tb_wb_counter_csr;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i, wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        cnt_en_o, cnt_dir_o, cnt_load_o;
    logic [31:0] cnt_load_val_o, cnt_cmp_o, cnt_val_i;
    logic        cnt_match_i;
    logic        irq_o;

    int          n_compared = 0;
    int          n_failed   = 0;

    logic [31:0] rd;
    logic        ak;
    int          lat;
    logic        ld;
    logic [31:0] ldv;
    int          n_acks;

    wb_counter_csr dut (
        .wb_clk_i       (wb_clk_i),
        .wb_rst_i       (wb_rst_i),
        .wbs_stb_i      (wbs_stb_i),
        .wbs_cyc_i      (wbs_cyc_i),
        .wbs_we_i       (wbs_we_i),
        .wbs_sel_i      (wbs_sel_i),
        .wbs_adr_i      (wbs_adr_i),
        .wbs_dat_i      (wbs_dat_i),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .cnt_en_o       (cnt_en_o),
        .cnt_dir_o      (cnt_dir_o),
        .cnt_load_o     (cnt_load_o),
        .cnt_load_val_o (cnt_load_val_o),
        .cnt_cmp_o      (cnt_cmp_o),
        .cnt_val_i      (cnt_val_i),
        .cnt_match_i    (cnt_match_i),
        .irq_o          (irq_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // One comparison: counted, and reported on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_compared++;
        assert (observed === expected)
        else begin
            n_failed++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One Wishbone access, bounded to 16 cycles. Optionally raises
    // cnt_match_i in the same cycle as the strobe. Leaves one idle cycle
    // after the ack so the next access starts clean.
    task automatic applyStimulus(input logic [31:0] adr, input logic [31:0] dat,
                                 input logic we, input logic [3:0] sel,
                                 input logic match_with,
                                 output logic [31:0] rdata, output logic acked,
                                 output int latency, output logic load_at_ack,
                                 output logic [31:0] load_val_at_ack);
        rdata = 32'd0;
        acked = 1'b0;
        latency = 0;
        load_at_ack = 1'b0;
        load_val_at_ack = 32'd0;
        wbs_adr_i   = adr;
        wbs_dat_i   = dat;
        wbs_we_i    = we;
        wbs_sel_i   = sel;
        wbs_cyc_i   = 1'b1;
        wbs_stb_i   = 1'b1;
        cnt_match_i = match_with;
        for (int i = 1; i <= 16; i++) begin
            @(posedge wb_clk_i);
            #1;
            cnt_match_i = 1'b0;
            if (wbs_ack_o) begin
                acked = 1'b1;
                latency = i;
                rdata = wbs_dat_o;
                load_at_ack = cnt_load_o;
                load_val_at_ack = cnt_load_val_o;
                break;
            end
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
    endtask

    initial begin
        wb_rst_i    = 1'b1;
        wbs_stb_i   = 1'b0;
        wbs_cyc_i   = 1'b0;
        wbs_we_i    = 1'b0;
        wbs_sel_i   = 4'h0;
        wbs_adr_i   = 32'd0;
        wbs_dat_i   = 32'd0;
        cnt_val_i   = 32'd0;
        cnt_match_i = 1'b0;

        // Reset defaults
        repeat (2) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        checkOutput("rst_ack",  {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("rst_dat",  wbs_dat_o, 32'd0);
        checkOutput("rst_load", {31'd0, cnt_load_o}, 32'd0);
        checkOutput("rst_irq",  {31'd0, irq_o}, 32'd0);
        checkOutput("rst_en",   {31'd0, cnt_en_o}, 32'd0);
        checkOutput("rst_cmp",  cnt_cmp_o, 32'd0);

        applyStimulus(BASE + 32'h00, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("rst_ctrl_ack", {31'd0, ak}, 32'd1);
        checkOutput("rst_ack_latency", lat, 32'd1);
        checkOutput("rst_ctrl_rd", rd, 32'd0);
        applyStimulus(BASE + 32'h04, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("rst_load_rd", rd, 32'd0);
        applyStimulus(BASE + 32'h08, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("rst_count_rd", rd, 32'd0);
        applyStimulus(BASE + 32'h0C, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("rst_cmp_rd", rd, 32'd0);
        applyStimulus(BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("rst_status_rd", rd, 32'd0);

        // Byte merge on CMP
        applyStimulus(BASE + 32'h0C, 32'hAABB_CCDD, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("cmp_wr_dat_zero", rd, 32'd0);
        applyStimulus(BASE + 32'h0C, 32'h1122_3344, 1'b1, 4'b0101, 1'b0, rd, ak, lat, ld, ldv);
        applyStimulus(BASE + 32'h0C, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("cmp_merge_rd", rd, 32'hAA22_CC44);
        checkOutput("cmp_out", cnt_cmp_o, 32'hAA22_CC44);
        checkOutput("dat_idle_zero", wbs_dat_o, 32'd0);

        // Load strobe
        applyStimulus(BASE + 32'h04, 32'h0000_0010, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("load_strobe_at_ack", {31'd0, ld}, 32'd1);
        checkOutput("load_val_at_ack", ldv, 32'h0000_0010);
        checkOutput("load_strobe_after", {31'd0, cnt_load_o}, 32'd0);
        applyStimulus(BASE + 32'h04, 32'h0000_00FF, 1'b1, 4'h0, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("load_sel0_ack", {31'd0, ak}, 32'd1);
        checkOutput("load_sel0_strobe", {31'd0, ld}, 32'd0);
        applyStimulus(BASE + 32'h04, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("load_sel0_keep", rd, 32'h0000_0010);

        // Live count, writes ignored
        cnt_val_i = 32'hDEAD_BEEF;
        applyStimulus(BASE + 32'h08, 32'h5555_5555, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        applyStimulus(BASE + 32'h08, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("count_rd", rd, 32'hDEAD_BEEF);

        // CTRL outputs
        applyStimulus(BASE + 32'h00, 32'hFFFF_FFFF, 1'b1, 4'h1, 1'b0, rd, ak, lat, ld, ldv);
        applyStimulus(BASE + 32'h00, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("ctrl_rd_7", rd, 32'h7);
        checkOutput("ctrl_dir", {31'd0, cnt_dir_o}, 32'd1);
        applyStimulus(BASE + 32'h00, 32'h3, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("ctrl_en", {31'd0, cnt_en_o}, 32'd1);
        checkOutput("ctrl_dir_up", {31'd0, cnt_dir_o}, 32'd0);
        checkOutput("irq_before_match", {31'd0, irq_o}, 32'd0);

        // Interrupt flow
        cnt_match_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        cnt_match_i = 1'b0;
        checkOutput("irq_after_match", {31'd0, irq_o}, 32'd1);
        applyStimulus(BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("status_set", rd, 32'd1);
        applyStimulus(BASE + 32'h10, 32'h1, 1'b1, 4'h1, 1'b1, rd, ak, lat, ld, ldv);
        checkOutput("w1c_vs_match_irq", {31'd0, irq_o}, 32'd1);
        applyStimulus(BASE + 32'h10, 32'h1, 1'b1, 4'h2, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("w1c_sel_lane1_no_clear", {31'd0, irq_o}, 32'd1);
        applyStimulus(BASE + 32'h10, 32'h1, 1'b1, 4'h1, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("w1c_irq_low", {31'd0, irq_o}, 32'd0);
        applyStimulus(BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("w1c_status_rd", rd, 32'd0);

        // Masked match still sets STATUS
        applyStimulus(BASE + 32'h00, 32'h1, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        cnt_match_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        cnt_match_i = 1'b0;
        checkOutput("masked_irq", {31'd0, irq_o}, 32'd0);
        applyStimulus(BASE + 32'h10, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("masked_status", rd, 32'd1);
        applyStimulus(BASE + 32'h00, 32'h3, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("unmask_irq", {31'd0, irq_o}, 32'd1);

        // Decode
        applyStimulus(32'h3000_0100, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("miss_no_ack", {31'd0, ak}, 32'd0);
        applyStimulus(BASE + 32'h20, 32'hFFFF_FFFF, 1'b1, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        applyStimulus(BASE + 32'h20, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("hole_ack", {31'd0, ak}, 32'd1);
        checkOutput("hole_rd", rd, 32'd0);
        applyStimulus(BASE + 32'h0F, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("low_adr_ignored", rd, 32'hAA22_CC44);

        // Held strobe: acks at most every other cycle
        n_acks = 0;
        wbs_adr_i = BASE;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge wb_clk_i);
            #1;
            if (wbs_ack_o) n_acks++;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        @(posedge wb_clk_i);
        #1;
        checkOutput("held_stb_acks", n_acks, 32'd3);

        // Strobe without cycle is not an access
        wbs_stb_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        checkOutput("no_cyc_no_ack", {31'd0, wbs_ack_o}, 32'd0);
        wbs_stb_i = 1'b0;

        // Reset in the middle of a LOAD write
        wbs_adr_i = BASE + 32'h04;
        wbs_dat_i = 32'h0000_0055;
        wbs_we_i  = 1'b1;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wb_rst_i  = 1'b1;
        @(posedge wb_clk_i);
        #1;
        checkOutput("midrst_ack", {31'd0, wbs_ack_o}, 32'd0);
        checkOutput("midrst_load", {31'd0, cnt_load_o}, 32'd0);
        checkOutput("midrst_irq", {31'd0, irq_o}, 32'd0);
        wb_rst_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge wb_clk_i);
        #1;
        applyStimulus(BASE + 32'h04, 32'd0, 1'b0, 4'hF, 1'b0, rd, ak, lat, ld, ldv);
        checkOutput("midrst_load_reg", rd, 32'd0);
        checkOutput("midrst_ctrl", {31'd0, cnt_en_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule
